// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for alu_arbiter: two request channels, two response
// channels and the shared response payload.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_flags;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_data, rsp_flags, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_data, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU between two requesters, one
// operation in flight, with a watchdog that answers with an error response.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 5,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic             alu_en,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_valid,
  input  logic [WIDTH-1:0] alu_data,
  input  logic [2:0]       alu_flags,
  output logic             busy
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             prio_r;
  logic             gnt_r;
  logic [OPW-1:0]   op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WDW-1:0]   wd_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic [2:0]       rsp_flags_r;
  logic             rsp_err_r;
  logic             rsp0_valid_r;
  logic             rsp1_valid_r;
  logic             alu_en_r;
  logic             busy_r;
  logic             rdy0_s;
  logic             rdy1_s;
  logic             cap_s;
  logic             tmo_s;

  // Next-state, grant selection and capture/timeout decisions.
  always_comb begin
    state_s = state_r;
    rdy0_s  = 1'b0;
    rdy1_s  = 1'b0;
    cap_s   = 1'b0;
    tmo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req0_valid && (!bus.req1_valid || !prio_r)) begin
          rdy0_s  = 1'b1;
          state_s = ISSUE;
        end else if (bus.req1_valid) begin
          rdy1_s  = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (alu_valid) begin
          cap_s   = 1'b1;
          state_s = RESP;
        end else if (wd_r == WD_LAST) begin
          tmo_s   = 1'b1;
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (gnt_r ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latched operation, watchdog, captured response and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_r       <= 1'b0;
      gnt_r        <= 1'b0;
      op_r         <= {OPW{1'b0}};
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      wd_r         <= {WDW{1'b0}};
      rsp_data_r   <= {WIDTH{1'b0}};
      rsp_flags_r  <= 3'b000;
      rsp_err_r    <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      alu_en_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (rdy0_s || rdy1_s) begin
        op_r   <= rdy1_s ? bus.req1_op : bus.req0_op;
        a_r    <= rdy1_s ? bus.req1_a  : bus.req0_a;
        b_r    <= rdy1_s ? bus.req1_b  : bus.req0_b;
        gnt_r  <= rdy1_s;
        prio_r <= ~rdy1_s;
      end
      if (state_r == ISSUE) begin
        wd_r <= {WDW{1'b0}};
      end else if (state_r == WAIT) begin
        wd_r <= wd_r + WDW'(1);
      end
      if (cap_s) begin
        rsp_data_r  <= alu_data;
        rsp_flags_r <= alu_flags;
        rsp_err_r   <= 1'b0;
      end else if (tmo_s) begin
        rsp_data_r  <= {WIDTH{1'b0}};
        rsp_flags_r <= 3'b000;
        rsp_err_r   <= 1'b1;
      end
      // Outputs are registered from the next state so they track it exactly.
      alu_en_r     <= (state_s == ISSUE);
      busy_r       <= (state_s != IDLE);
      rsp0_valid_r <= (state_s == RESP) && !gnt_r;
      rsp1_valid_r <= (state_s == RESP) && gnt_r;
    end
  end

  assign bus.req0_ready = rdy0_s;
  assign bus.req1_ready = rdy1_s;
  assign bus.rsp0_valid = rsp0_valid_r;
  assign bus.rsp1_valid = rsp1_valid_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_flags  = rsp_flags_r;
  assign bus.rsp_err    = rsp_err_r;
  assign alu_en         = alu_en_r;
  assign alu_op         = op_r;
  assign alu_a          = a_r;
  assign alu_b          = b_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level
// model of arbitration order, latency and response contents.
module tb_alu_arbiter;
  localparam int TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_valid;
  logic [31:0] alu_data;
  logic [2:0]  alu_flags;
  logic        busy;
  logic        alu_block;
  logic        alu_inject;
  int          n_chk;
  int          n_pass;
  int          model_prio;

  alu_arbiter_if #(.WIDTH(32), .OPW(5)) bus ();

  alu_arbiter #(.WIDTH(32), .OPW(5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst_n), .bus(bus),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_valid(alu_valid), .alu_data(alu_data), .alu_flags(alu_flags),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_data(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      5'd1:    return a + b;
      5'd2:    return a & b;
      5'd3:    return a - b;
      5'd4:    return a | b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    if (op == 5'd5) return {a == b, a > b, a < b};
    return {ref_data(op, a, b) == 32'd0, 2'b00};
  endfunction

  // One-cycle registered ALU; alu_block suppresses valid, alu_inject forces a stray pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid <= 1'b0;
      alu_data  <= 32'd0;
      alu_flags <= 3'b000;
    end else begin
      alu_valid <= (alu_en && !alu_block) || alu_inject;
      alu_data  <= ref_data(alu_op, alu_a, alu_b);
      alu_flags <= ref_flags(alu_op, alu_a, alu_b);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = 5'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_op = 5'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    alu_block = 1'b0; alu_inject = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_prio = 0;
    tick();
  endtask

  // One complete request/response; called only with the arbiter idle.
  task automatic transact(input bit v0, input bit v1,
                          input logic [4:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [4:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                          input bit blk, input int hold, input bit keep);
    int w;
    int n;
    logic [4:0]  eop;
    logic [31:0] ea, eb, ed;
    logic [2:0]  ef, wf;
    w   = (v0 && v1) ? model_prio : (v1 ? 1 : 0);
    eop = (w == 1) ? op1 : op0;
    ea  = (w == 1) ? a1 : a0;
    eb  = (w == 1) ? b1 : b0;
    ed  = blk ? 32'd0 : ref_data(eop, ea, eb);
    ef  = blk ? 3'b000 : ref_flags(eop, ea, eb);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    alu_block = blk;
    #1;
    chk("req0_ready_idle", 64'(bus.req0_ready), 64'(w == 0));
    chk("req1_ready_idle", 64'(bus.req1_ready), 64'(w == 1));
    tick();
    model_prio = 1 - w;
    bus.req0_valid = keep && (w == 1);
    bus.req1_valid = keep && (w == 0);
    #1;
    chk("alu_en_issue", 64'(alu_en), 64'd1);
    chk("alu_op", 64'(alu_op), 64'(eop));
    chk("alu_a", 64'(alu_a), 64'(ea));
    chk("alu_b", 64'(alu_b), 64'(eb));
    chk("busy_issue", 64'(busy), 64'd1);
    tick();
    wf = alu_flags;
    chk("alu_en_wait", 64'(alu_en), 64'd0);
    chk("alu_b_held", 64'(alu_b), 64'(eb));
    n = 2;
    while (!(bus.rsp0_valid || bus.rsp1_valid) && n < TIMEOUT + 6) begin
      tick();
      n++;
    end
    chk("rsp_latency", 64'(n), 64'(blk ? TIMEOUT + 2 : 3));
    chk("rsp_own_valid", 64'(w == 1 ? bus.rsp1_valid : bus.rsp0_valid), 64'd1);
    chk("rsp_other_valid", 64'(w == 1 ? bus.rsp0_valid : bus.rsp1_valid), 64'd0);
    chk("rsp_data", 64'(bus.rsp_data), 64'(ed));
    chk("rsp_flags", 64'(bus.rsp_flags), 64'(ef));
    chk("rsp_err", 64'(bus.rsp_err), 64'(blk));
    if (!blk) chk("flags_vs_wait", 64'(bus.rsp_flags), 64'(wf));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 64'(w == 1 ? bus.rsp1_valid : bus.rsp0_valid), 64'd1);
      chk("hold_data", 64'(bus.rsp_data), 64'(ed));
      chk("hold_no_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    end
    if (w == 1) bus.rsp1_ready = 1'b1;
    else bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    alu_block = 1'b0;
    #1;
    chk("rsp_dropped", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("data_kept", 64'(bus.rsp_data), 64'(ed));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b1;
    model_prio = 0;
    clear_inputs();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_en", 64'(alu_en), 64'd0);
    chk("rst_rsp_valid", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'd0);
    chk("rst_rsp", 64'({bus.rsp_data, bus.rsp_flags, bus.rsp_err}), 64'd0);
    chk("rst_alu_ops", 64'({alu_op, alu_a}), 64'd0);
    do_reset();

    // Single request on req0.
    transact(1'b1, 1'b0, 5'd1, 32'd5, 32'd7, 5'd0, 32'd0, 32'd0, 1'b0, 0, 1'b0);

    // Both requesting after reset: strict alternation starting with req0.
    do_reset();
    for (int k = 0; k < 4; k++)
      transact(1'b1, 1'b1, 5'd1, 32'd1, 32'd2, 5'd3, 32'd10, 32'd3, 1'b0, 0, 1'b0);

    // Stalled response on req1 while req0 waits.
    transact(1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 5'd3, 32'd10, 32'd3, 1'b0, 5, 1'b1);
    transact(1'b1, 1'b0, 5'd1, 32'd4, 32'd4, 5'd0, 32'd0, 32'd0, 1'b0, 0, 1'b0);

    // Watchdog error, then a normal operation.
    transact(1'b1, 1'b0, 5'd1, 32'd9, 32'd9, 5'd0, 32'd0, 32'd0, 1'b1, 0, 1'b0);
    transact(1'b1, 1'b0, 5'd3, 32'd20, 32'd5, 5'd0, 32'd0, 32'd0, 1'b0, 0, 1'b0);

    // Compare ops and an unsupported code.
    transact(1'b1, 1'b0, 5'd5, 32'd9, 32'd4, 5'd0, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    transact(1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 5'd5, 32'd6, 32'd6, 1'b0, 0, 1'b0);
    transact(1'b1, 1'b0, 5'd31, 32'd3, 32'd3, 5'd0, 32'd0, 32'd0, 1'b0, 1, 1'b0);

    // Reset during WAIT aborts the operation.
    alu_block = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_op = 5'd1; bus.req1_a = 32'd8; bus.req1_b = 32'd8;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    tick();
    chk("busy_before_rst", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_alu_en", 64'(alu_en), 64'd0);
    chk("async_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    chk("async_rsp_valid", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'd0);
    tick();
    rst_n = 1'b1;
    model_prio = 0;
    alu_block = 1'b0;
    alu_inject = 1'b1;
    tick();
    alu_inject = 1'b0;
    chk("late_pulse_seen", 64'(alu_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("late_no_rsp", 64'({bus.rsp0_valid, bus.rsp1_valid, busy}), 64'd0);
      tick();
    end
    transact(1'b1, 1'b1, 5'd1, 32'd100, 32'd1, 5'd3, 32'd7, 32'd2, 1'b0, 0, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int sel;
      logic [4:0]  o0, o1;
      logic [31:0] x0, y0, x1, y1;
      sel = int'($urandom_range(1, 3));
      o0 = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 5));
      o1 = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 5));
      x0 = $urandom;
      x1 = $urandom;
      y0 = ($urandom_range(0, 3) == 0) ? x0 : $urandom;
      y1 = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
      transact(sel[0], sel[1], o0, x0, y0, o1, x1, y1,
               $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
